// File: rtl/axi_burst_wr_ctrl.sv
// AXI burst write controller: turns a single-cycle user request into one
// AXI address handshake followed by len+1 data beats, then a done pulse.
//
// Ports:
//   clk_100M, rstn           clock and synchronous active-low reset
//   init_done                DDR init complete; requests are ignored while low
//   wr_req/wr_addr/wr_len    request pulse with burst start address and beats-1
//   wr_data/wr_data_req      first-word-fall-through user beat / beat consumed
//   wr_busy/wr_done/wr_err   status: busy, completion pulse, timeout pulse
//   axi_aw*                  AXI write address channel
//   axi_w*, axi_wusero_last  AXI write data channel
//
// Optional feature: define AXI_WR_TIMEOUT_EN to abort a burst that waits
// TIMEOUT cycles on a ready without a handshake (wr_err pulse, no wr_done).
module axi_burst_wr_ctrl #(
   parameter int ADDR_W  = 28,
   parameter int DATA_W  = 256,
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                clk_100M,
   input  logic                rstn,
   input  logic                init_done,
   input  logic                wr_req,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [LEN_W-1:0]    wr_len,
   input  logic [DATA_W-1:0]   wr_data,
   output logic                wr_data_req,
   output logic                wr_busy,
   output logic                wr_done,
   output logic                wr_err,
   output logic [ADDR_W-1:0]   axi_awaddr,
   output logic [LEN_W-1:0]    axi_awlen,
   output logic                axi_awvalid,
   input  logic                axi_awready,
   output logic [DATA_W-1:0]   axi_wdata,
   output logic [DATA_W/8-1:0] axi_wstrb,
   input  logic                axi_wready,
   output logic                axi_wusero_last
);

   if ((DATA_W % 8) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("axi_burst_wr_ctrl: DATA_W must be a multiple of 8, TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_cnt;
   logic                r_awvalid;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   logic w_in_data;
   logic w_aw_hs;
   logic w_beat;
   logic w_last;
   logic w_tmo_hit;

   assign w_in_data = (r_state == S_DATA);
   assign w_aw_hs   = (r_state == S_ADDR) & axi_awready;
   assign w_beat    = w_in_data & axi_wready;
   assign w_last    = w_in_data & (r_cnt == r_len);

`ifdef AXI_WR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] r_tmo;

   assign w_tmo_hit = ((r_state == S_ADDR) | w_in_data) &
                      ~(w_aw_hs | w_beat) &
                      (r_tmo == TW'(TIMEOUT - 1));

   // Restarts from zero whenever a wait begins: on entry to ADDR (held at
   // zero in IDLE), on entry to DATA (the address handshake) and per beat.
   always_ff @(posedge clk_100M) begin
      if (!rstn) begin
         r_tmo <= '0;
      end else if (!((r_state == S_ADDR) | w_in_data) | w_aw_hs | w_beat) begin
         r_tmo <= '0;
      end else begin
         r_tmo <= r_tmo + 1'b1;
      end
   end
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk_100M) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_awvalid <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (wr_req && init_done) begin
                  r_addr    <= wr_addr;
                  r_len     <= wr_len;
                  r_awvalid <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (axi_awready) begin
                  r_awvalid <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= S_DATA;
               end else if (w_tmo_hit) begin
                  r_awvalid <= 1'b0;
                  r_busy    <= 1'b0;
                  r_err     <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            S_DATA: begin
               if (axi_wready) begin
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else if (w_tmo_hit) begin
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wr_data_req     = w_beat;
   assign wr_busy         = r_busy;
   assign wr_done         = r_done;
   assign wr_err          = r_err;
   assign axi_awaddr      = r_addr;
   assign axi_awlen       = r_len;
   assign axi_awvalid     = r_awvalid;
   assign axi_wdata       = wr_data;
   assign axi_wstrb       = '1;
   assign axi_wusero_last = w_last;

endmodule

// File: tb/tb_axi_burst_wr_ctrl.sv
// Self-checking bench for axi_burst_wr_ctrl: randomized bursts checked
// against a transaction-level model of the address/data/done sequence.
module tb_axi_burst_wr_ctrl;

   localparam int AW  = 28;
   localparam int DW  = 64;
   localparam int LW  = 4;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          init_done;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [LW-1:0] wr_len;
   logic [DW-1:0] wr_data;
   logic          wr_data_req;
   logic          wr_busy;
   logic          wr_done;
   logic          wr_err;
   logic [AW-1:0] axi_awaddr;
   logic [LW-1:0] axi_awlen;
   logic          axi_awvalid;
   logic          axi_awready;
   logic [DW-1:0] axi_wdata;
   logic [DW/8-1:0] axi_wstrb;
   logic          axi_wready;
   logic          axi_wusero_last;

   int cmp = 0;
   int bad = 0;

   always #5 clk = ~clk;

   axi_burst_wr_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(TMO)
   ) dut (
      .clk_100M(clk), .rstn(rstn), .init_done(init_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
      .wr_data(wr_data), .wr_data_req(wr_data_req),
      .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err),
      .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
      .axi_wready(axi_wready), .axi_wusero_last(axi_wusero_last)
   );

   // One burst. The model walks the expected transaction: address phase
   // until the first awready, then len+1 accepted beats carrying the user
   // words in order, then exactly one done cycle, then idle.
   task automatic run_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input int aw_delay, input int w_mode,
                            input bit inject, output int busy_cyc);
      logic [DW-1:0] beats [16];
      int k, phase, n, adly;
      bit tog;
      for (int i = 0; i < 16; i++) beats[i] = {$urandom, $urandom};
      busy_cyc = 0; k = 0; phase = 0; n = 0; adly = 0; tog = 1'b0;
      @(negedge clk);
      wr_req = 1'b1; wr_addr = a; wr_len = l;
      axi_awready = 1'b0; axi_wready = 1'b0; wr_data = beats[0];
      @(negedge clk);
      while (phase < 4 && n < 300) begin
         wr_req  = inject && (n == 1);
         wr_addr = AW'($urandom);
         wr_len  = LW'($urandom);
         axi_awready = (adly >= aw_delay);
         case (w_mode)
            0:       axi_wready = 1'b1;
            1:       axi_wready = tog;
            default: axi_wready = ($urandom_range(0, 3) != 0);
         endcase
         tog = ~tog;
         wr_data = (k < 16) ? beats[k] : '0;
         #1;
         busy_cyc += int'(wr_busy);
         cmp++;
         if (wr_err !== 1'b0) begin
            bad++; $display("FAIL err_idle: got %b want 0", wr_err);
         end
         case (phase)
            0: begin
               cmp++;
               if (axi_awvalid !== 1'b1) begin
                  bad++; $display("FAIL awvalid_addr: got %b want 1", axi_awvalid);
               end
               cmp++;
               if ({axi_awaddr, axi_awlen} !== {a, l}) begin
                  bad++; $display("FAIL aw_fields: got %h/%h want %h/%h",
                                  axi_awaddr, axi_awlen, a, l);
               end
               cmp++;
               if (wr_data_req !== 1'b0) begin
                  bad++; $display("FAIL dreq_addr: got %b want 0", wr_data_req);
               end
               cmp++;
               if (wr_busy !== 1'b1) begin
                  bad++; $display("FAIL busy_addr: got %b want 1", wr_busy);
               end
               if (axi_awready) phase = 1;
               adly++;
            end
            1: begin
               cmp++;
               if (axi_awvalid !== 1'b0) begin
                  bad++; $display("FAIL awvalid_data: got %b want 0", axi_awvalid);
               end
               cmp++;
               if (wr_busy !== 1'b1) begin
                  bad++; $display("FAIL busy_data: got %b want 1", wr_busy);
               end
               cmp++;
               if (axi_wusero_last !== (k == int'(l))) begin
                  bad++; $display("FAIL last: beat %0d got %b want %b",
                                  k, axi_wusero_last, (k == int'(l)));
               end
               if (axi_wready) begin
                  cmp++;
                  if (wr_data_req !== 1'b1) begin
                     bad++; $display("FAIL dreq_beat: got %b want 1", wr_data_req);
                  end
                  cmp++;
                  if (axi_wdata !== beats[k]) begin
                     bad++; $display("FAIL wdata: beat %0d got %h want %h",
                                     k, axi_wdata, beats[k]);
                  end
                  cmp++;
                  if (axi_wstrb !== {(DW/8){1'b1}}) begin
                     bad++; $display("FAIL wstrb: got %h want all ones", axi_wstrb);
                  end
                  k++;
                  if (k == int'(l) + 1) phase = 2;
               end else begin
                  cmp++;
                  if (wr_data_req !== 1'b0) begin
                     bad++; $display("FAIL dreq_stall: got %b want 0", wr_data_req);
                  end
               end
            end
            2: begin
               cmp++;
               if ({wr_done, wr_busy, wr_data_req, axi_wusero_last} !== 4'b1100) begin
                  bad++; $display("FAIL done_cycle: got %b want 1100",
                                  {wr_done, wr_busy, wr_data_req, axi_wusero_last});
               end
               phase = 3;
            end
            default: begin
               cmp++;
               if ({wr_done, wr_busy, axi_awvalid} !== 3'b000) begin
                  bad++; $display("FAIL after_done: got %b want 000",
                                  {wr_done, wr_busy, axi_awvalid});
               end
               phase = 4;
            end
         endcase
         n++;
         if (phase < 4) @(negedge clk);
      end
      wr_req = 1'b0;
      cmp++;
      if (phase != 4) begin
         bad++; $display("FAIL burst_timeout: phase %0d want 4", phase);
      end
      cmp++;
      if (k != int'(l) + 1) begin
         bad++; $display("FAIL beat_count: got %0d want %0d", k, int'(l) + 1);
      end
   endtask

   task automatic check_quiet(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk); #1;
         cmp++;
         if ({axi_awvalid, wr_busy, wr_done, wr_data_req} !== 4'b0000) begin
            bad++; $display("FAIL %s: got %b want 0000", tag,
                            {axi_awvalid, wr_busy, wr_done, wr_data_req});
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; init_done = 1'b0; wr_req = 1'b0;
      wr_addr = '0; wr_len = '0; wr_data = '0;
      axi_awready = 1'b1; axi_wready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      cmp++;
      if ({axi_awvalid, wr_busy, wr_done, wr_err, wr_data_req,
           axi_wusero_last} !== 6'b0) begin
         bad++; $display("FAIL reset_outs: got %b want 000000",
                         {axi_awvalid, wr_busy, wr_done, wr_err,
                          wr_data_req, axi_wusero_last});
      end
      cmp++;
      if ({axi_awaddr, axi_awlen} !== '0) begin
         bad++; $display("FAIL reset_aw: got %h/%h want 0/0", axi_awaddr, axi_awlen);
      end
      rstn = 1'b1;
      init_done = 1'b1;
   endtask

   task automatic test_basic();
      int bc;
      run_burst(AW'('h100), LW'(3), 0, 0, 1'b0, bc);
      cmp++;
      if (bc != 6) begin
         bad++; $display("FAIL busy_len: got %0d want 6", bc);
      end
   endtask

   task automatic test_single_toggle();
      int bc;
      run_burst(AW'($urandom), LW'(0), 0, 1, 1'b0, bc);
   endtask

   task automatic test_aw_stall();
      int bc;
      run_burst(AW'($urandom), LW'(15), 5, 0, 1'b0, bc);
      cmp++;
      if (bc != 6 + 16 + 1) begin
         bad++; $display("FAIL busy_stall: got %0d want %0d", bc, 6 + 16 + 1);
      end
   endtask

   task automatic test_drop();
      int bc;
      @(negedge clk);
      init_done = 1'b0; wr_req = 1'b1; wr_addr = AW'($urandom); wr_len = LW'(2);
      @(negedge clk);
      wr_req = 1'b0;
      init_done = 1'b1;
      #1;
      cmp++;
      if ({axi_awvalid, wr_busy} !== 2'b00) begin
         bad++; $display("FAIL drop_init: got %b want 00", {axi_awvalid, wr_busy});
      end
      check_quiet(3, "drop_init_q");
      run_burst(AW'($urandom), LW'(2), 3, 2, 1'b1, bc);
      check_quiet(4, "drop_busy_q");
   endtask

   task automatic test_mid_reset();
      int bc;
      @(negedge clk);
      wr_req = 1'b1; wr_addr = AW'($urandom); wr_len = LW'(7);
      axi_awready = 1'b1; axi_wready = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      cmp++;
      if (!(wr_busy && wr_data_req)) begin
         bad++; $display("FAIL mid_setup: got %b want 11", {wr_busy, wr_data_req});
      end
      rstn = 1'b0;
      @(negedge clk); #1;
      cmp++;
      if ({axi_awvalid, wr_busy, wr_done, wr_err, wr_data_req,
           axi_wusero_last} !== 6'b0) begin
         bad++; $display("FAIL mid_reset: got %b want 000000",
                         {axi_awvalid, wr_busy, wr_done, wr_err,
                          wr_data_req, axi_wusero_last});
      end
      cmp++;
      if ({axi_awaddr, axi_awlen} !== '0) begin
         bad++; $display("FAIL mid_reset_aw: got %h/%h want 0/0",
                         axi_awaddr, axi_awlen);
      end
      rstn = 1'b1;
      check_quiet(4, "mid_reset_q");
      run_burst(AW'($urandom), LW'(7), 1, 2, 1'b0, bc);
   endtask

   task automatic test_random();
      int bc;
      for (int t = 0; t < 12; t++) begin
         run_burst(AW'($urandom), LW'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 2), 1'($urandom), bc);
      end
   endtask

`ifdef AXI_WR_TIMEOUT_EN
   task automatic test_timeout();
      @(negedge clk);
      wr_req = 1'b1; wr_addr = AW'($urandom); wr_len = LW'(1);
      axi_awready = 1'b1; axi_wready = 1'b0;
      @(negedge clk);
      wr_req = 1'b0;
      @(negedge clk);
      for (int m = 0; m <= TMO; m++) begin
         #1;
         cmp++;
         if (m < TMO && {wr_err, wr_busy, wr_done} !== 3'b010) begin
            bad++; $display("FAIL tmo_wait: cyc %0d got %b want 010", m,
                            {wr_err, wr_busy, wr_done});
         end else if (m == TMO && {wr_err, wr_busy, wr_done} !== 3'b100) begin
            bad++; $display("FAIL tmo_hit: got %b want 100",
                            {wr_err, wr_busy, wr_done});
         end
         @(negedge clk);
      end
      #1;
      cmp++;
      if ({wr_err, wr_done, axi_awvalid} !== 3'b000) begin
         bad++; $display("FAIL tmo_pulse: got %b want 000",
                         {wr_err, wr_done, axi_awvalid});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_single_toggle();
      test_aw_stall();
      test_drop();
      test_mid_reset();
      test_random();
`ifdef AXI_WR_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule

// File: doc/axi_burst_wr_ctrl.md
AXI_BURST_WR_CTRL -- requirements
Module: axi_burst_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, AXI/user address width.
REQ-002 SHALL have parameter DATA_W, default 256, data beat width (multiple of 8).
REQ-003 SHALL have parameter LEN_W, default 4, burst length field width; burst beats = len+1.
REQ-004 SHALL have parameter TIMEOUT, default 1023, max cycles waiting on any AXI ready (only with timeout macro).
REQ-005 SHALL have port clk_100M  in  1  sole clock; one clock; all logic on rising edge.
REQ-006 SHALL have port rstn  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port init_done  in  1  DDR init complete; requests ignored while low.
REQ-008 SHALL have port wr_req  in  1  single-cycle request pulse.
REQ-009 SHALL have port wr_addr  in  ADDR_W  burst start address, sampled with wr_req.
REQ-010 SHALL have port wr_len  in  LEN_W  beats-1, sampled with wr_req.
REQ-011 SHALL have port wr_data  in  DATA_W  current user beat (first-word-fall-through).
REQ-012 SHALL have port wr_data_req  out  1  beat consumed; user presents next beat on the following cycle.
REQ-013 SHALL have port wr_busy  out  1  high from acceptance until DONE exits.
REQ-014 SHALL have port wr_done  out  1  one-cycle completion pulse.
REQ-015 SHALL have port wr_err  out  1  one-cycle timeout pulse (tied 0 without macro).
REQ-016 SHALL have ports axi_awaddr out ADDR_W, axi_awlen out LEN_W, axi_awvalid out 1, axi_awready in 1.
REQ-017 SHALL have ports axi_wdata out DATA_W, axi_wstrb out DATA_W/8, axi_wready in 1, axi_wusero_last out 1.

Function
REQ-018 SHALL implement states IDLE, ADDR, DATA, DONE.
REQ-019 IDLE->ADDR on wr_req & init_done; wr_addr/wr_len registered that edge; wr_req in any other state or with init_done low SHALL be dropped.
REQ-020 ADDR: axi_awvalid=1, awaddr/awlen stable; on awvalid&awready -> DATA next cycle, awvalid deasserted.
REQ-021 axi_wready during ADDR SHALL be ignored; no data beat before address accepted.
REQ-022 DATA: axi_wdata = wr_data (combinational), axi_wstrb all ones; beat transfers when axi_wready=1; wr_data_req = axi_wready in DATA, 0 otherwise.
REQ-023 Beat counter (LEN_W bits) SHALL clear on entering DATA, increment per transfer; axi_wusero_last = 1 exactly when counter==latched len in DATA.
REQ-024 Transfer with last=1 -> DONE; DONE lasts one cycle with wr_done=1, then IDLE.
REQ-025 wr_busy SHALL be 1 in ADDR, DATA, DONE; 0 in IDLE; wr_req accepted earliest the cycle after DONE.
REQ-026 len=0 SHALL produce a single beat with wusero_last on that beat; len=2^LEN_W-1 SHALL wrap nothing (counter max equals len).

Reset
REQ-027 rstn low at any edge, including mid-burst, SHALL force IDLE; axi_awvalid, wusero_last, wr_busy, wr_done, wr_err, wr_data_req, counters, latched addr/len = 0 next cycle; no partial-burst completion.

Configuration
REQ-028 Macro AXI_WR_TIMEOUT_EN defined: counter reset on each state entry and each handshake; reaching TIMEOUT in ADDR or DATA SHALL pulse wr_err one cycle, drop awvalid, go IDLE, no wr_done.
REQ-029 Macro undefined: no timeout logic; ADDR/DATA wait indefinitely; wr_err constant 0.

Verification
REQ-030 init_done=1, wr_req addr=0x100 len=3, awready/wready always 1 -> awvalid 1 cycle, 4 beats, last on beat 4, wr_done 1 cycle after last, busy 6 cycles.
REQ-031 len=0, wready toggling 0,1 -> single beat with last=1, wr_data_req exactly 1 pulse.
REQ-032 awready held 0 for 5 cycles while wready=1 -> no wr_data_req until address handshake, then 16 beats for len=15.
REQ-033 wr_req during busy and wr_req with init_done=0 -> both ignored, no awvalid.
REQ-034 rstn low at beat 2 of len=7 burst -> next cycle all outputs 0, IDLE; new request completes normally.
REQ-035 AXI_WR_TIMEOUT_EN, TIMEOUT=8, wready stuck 0 -> wr_err pulse 8 cycles after DATA entry, no wr_done, busy falls.
